// File: rtl/param_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : param_stream_source
// Brief    : Replays a constant parameter tensor from a pipelined ROM onto a
//            valid/ready stream, one PARALLELISM_DIM_0 x PARALLELISM_DIM_1 block per beat.
// Revision : 1.0 - initial release
// ============================================================================
module param_stream_source #(
    parameter int DATA_WIDTH        = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 1,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int ROM_LATENCY       = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter int REPEAT            = 0,
    localparam int P         = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    localparam int OUT_DEPTH = (TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0) *
                               (TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1),
    localparam int AWIDTH    = $clog2(OUT_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [AWIDTH-1:0]       rom_addr,
    output logic                    rom_ce,
    input  logic [DATA_WIDTH*P-1:0] rom_q,
    output logic [DATA_WIDTH-1:0]   data_out [P],
    output logic                    data_out_valid,
    input  logic                    data_out_ready
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;
    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(OUT_DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'((REPEAT > 0) ? REPEAT - 1 : 0);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam bit                FREE_RUN  = (REPEAT == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [AWIDTH-1:0]       addr_q, addr_d;
    logic [PASS_W-1:0]       pass_q, pass_d;
    logic [ROM_LATENCY-1:0]  tag_q, tag_d;
    logic                    ce_q;
    logic                    done_q, done_d;
    logic [DATA_WIDTH*P-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [SUM_W-1:0]        inflight;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    last_issue;
    logic                    final_pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + SUM_W'(tag_q[i]);
        end
    end

    assign data_out_valid = (count_q != '0);
    assign pop            = data_out_valid & data_out_ready;
    assign push           = tag_q[ROM_LATENCY-1];

    // Every issued read owns a FIFO slot from issue until it is popped, so the
    // ROM never needs to be stalled; a same-cycle pop frees its slot at once.
    assign issue      = (state_q == S_RUN) &&
                        ((inflight + SUM_W'(count_q)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop)));
    assign last_issue = issue && !FREE_RUN && (addr_q == LAST_ADDR) && (pass_q == LAST_PASS);
    assign final_pop  = pop && (inflight == '0) && (count_q == CNT_W'(1));

    always_comb begin
        tag_d    = tag_q << 1;
        tag_d[0] = issue;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start || FREE_RUN) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    pass_d  = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        pass_d = pass_q + PASS_W'(1);
                    end else begin
                        addr_d = addr_q + AWIDTH'(1);
                    end
                end
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (final_pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            pass_q   <= '0;
            tag_q    <= '0;
            ce_q     <= 1'b0;
            done_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pass_q   <= pass_d;
            tag_q    <= tag_d;
            ce_q     <= 1'b1;
            done_q   <= done_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rom_q;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign rom_addr = addr_q;
    assign rom_ce   = ce_q;

    // Head is masked while empty so the stream reads zero out of reset.
    generate
        for (genvar j = 0; j < P; j++) begin : g_lane
            assign data_out[j] = data_out_valid ?
                                 mem_q[rd_ptr_q][DATA_WIDTH*j +: DATA_WIDTH] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_stream_source
// Brief    : Self-checking bench; three instances (REPEAT 2, 1, 0) against a beat-index model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_stream_source;

    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam int AW  = 4;
    localparam int NB  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst_v, st, rdy, busy, done, ce, vld;
    logic [AW-1:0]   addr [3];
    logic [2*DW-1:0] rq   [3];
    logic [2*DW-1:0] pipe [3][LAT];
    logic [DW-1:0]   d0 [2];
    logic [DW-1:0]   d1 [2];
    logic [DW-1:0]   d2 [2];

    param_stream_source #(.DATA_WIDTH(DW), .TENSOR_SIZE_DIM_0(8), .TENSOR_SIZE_DIM_1(2),
        .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(1), .ROM_LATENCY(LAT), .FIFO_DEPTH(FD),
        .REPEAT(2)) u_r2 (
        .clk(clk), .rst(rst_v[0]), .start(st[0]), .busy(busy[0]), .done(done[0]),
        .rom_addr(addr[0]), .rom_ce(ce[0]), .rom_q(rq[0]), .data_out(d0),
        .data_out_valid(vld[0]), .data_out_ready(rdy[0]));

    param_stream_source #(.DATA_WIDTH(DW), .TENSOR_SIZE_DIM_0(8), .TENSOR_SIZE_DIM_1(2),
        .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(1), .ROM_LATENCY(LAT), .FIFO_DEPTH(FD),
        .REPEAT(1)) u_r1 (
        .clk(clk), .rst(rst_v[1]), .start(st[1]), .busy(busy[1]), .done(done[1]),
        .rom_addr(addr[1]), .rom_ce(ce[1]), .rom_q(rq[1]), .data_out(d1),
        .data_out_valid(vld[1]), .data_out_ready(rdy[1]));

    param_stream_source #(.DATA_WIDTH(DW), .TENSOR_SIZE_DIM_0(8), .TENSOR_SIZE_DIM_1(2),
        .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(1), .ROM_LATENCY(LAT), .FIFO_DEPTH(FD),
        .REPEAT(0)) u_r0 (
        .clk(clk), .rst(rst_v[2]), .start(st[2]), .busy(busy[2]), .done(done[2]),
        .rom_addr(addr[2]), .rom_ce(ce[2]), .rom_q(rq[2]), .data_out(d2),
        .data_out_valid(vld[2]), .data_out_ready(rdy[2]));

    // ROM: element j of block address a is 16*a + j, LAT cycles after the address.
    function automatic logic [2*DW-1:0] rom_word(input logic [AW-1:0] a);
        return {DW'(16 * a + 1), DW'(16 * a)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ce[k]) begin
                for (int s = LAT - 1; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
                pipe[k][0] <= rom_word(addr[k]);
            end
        end
    end
    assign rq[0] = pipe[0][LAT-1];
    assign rq[1] = pipe[1][LAT-1];
    assign rq[2] = pipe[2][LAT-1];

    int total_c, bad_c, cycle;
    int exp_n [3];
    bit pend [3];
    int done_cnt [3];
    int done_cyc [3];
    bit armed [3];
    int t0 [3];
    bit rnd [3];

    function automatic int rep(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 0);
    endfunction

    function automatic logic [DW-1:0] getd(input int k, input int j);
        case (k)
            0:       return d0[j];
            1:       return d1[j];
            default: return d2[j];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_c++;
        assert (obs === exp) else begin
            bad_c++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 0);
        chk($sformatf("rst_done%0d", k), 64'(done[k]), 0);
        chk($sformatf("rst_addr%0d", k), 64'(addr[k]), 0);
        chk($sformatf("rst_ce%0d", k), 64'(ce[k]), 0);
        chk($sformatf("rst_valid%0d", k), 64'(vld[k]), 0);
        chk($sformatf("rst_data0_%0d", k), 64'(getd(k, 0)), 0);
        chk($sformatf("rst_data1_%0d", k), 64'(getd(k, 1)), 0);
    endtask

    // Model: the n-th beat of a run carries block n mod 8; a run is 8*REPEAT beats.
    task automatic observe();
        for (int k = 0; k < 3; k++) begin
            if (!rst_v[k]) begin
                if (rep(k) > 0) begin
                    chk($sformatf("done%0d", k), 64'(done[k]), 64'(pend[k]));
                    if (pend[k]) begin
                        chk($sformatf("busy_at_done%0d", k), 64'(busy[k]), 0);
                        chk($sformatf("run_len%0d", k), 64'(exp_n[k]), 64'(NB * rep(k)));
                        exp_n[k] = 0;
                        pend[k] = 1'b0;
                        done_cnt[k]++;
                        done_cyc[k] = cycle;
                    end
                end else begin
                    chk("done_free_running", 64'(done[k]), 0);
                end
                if (vld[k]) begin
                    if (armed[k]) begin
                        chk($sformatf("first_valid_latency%0d", k), 64'(cycle - t0[k]), 2 + LAT);
                        armed[k] = 1'b0;
                    end
                    chk($sformatf("busy_with_valid%0d", k), 64'(busy[k]), 1);
                    for (int j = 0; j < 2; j++)
                        chk($sformatf("data%0d_beat%0d_el%0d", k, exp_n[k], j),
                            64'(getd(k, j)), 64'(16 * (exp_n[k] % NB) + j));
                    if (rdy[k]) begin
                        exp_n[k]++;
                        if (rep(k) > 0 && exp_n[k] == NB * rep(k)) pend[k] = 1'b1;
                    end
                end
            end
        end
        cycle++;
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) if (rnd[k]) rdy[k] = 1'($urandom % 2);
    endtask

    task automatic wait_done(input int k, input int budget);
        int n0;
        int i;
        n0 = done_cnt[k];
        i = 0;
        while (done_cnt[k] == n0 && i < budget) begin
            cyc();
            i++;
        end
        chk($sformatf("done_within_budget%0d", k), 64'(done_cnt[k] - n0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total_c = 0; bad_c = 0; cycle = 0;
        for (int k = 0; k < 3; k++) begin
            exp_n[k] = 0; pend[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
            armed[k] = 0; t0[k] = 0; rnd[k] = 0;
        end
        rst_v = 3'b111; st = 3'b000; rdy = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset(k);
        @(posedge clk); #1;

        // REPEAT=2, ready high: latency, gapless 16 beats, single done
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        cyc(); cyc();
        rdy[0] = 1'b1; st[0] = 1'b1; t0[0] = cycle; armed[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        chk("busy_after_start", 64'(busy[0]), 1);
        chk("first_addr", 64'(addr[0]), 0);
        wait_done(0, 60);
        chk("gapless_run_length", 64'(done_cyc[0] - t0[0]), 2 + LAT + 2 * NB);
        repeat (3) cyc();

        // REPEAT=1, consumer stalled: issue stops at credit limit, head holds
        rdy[1] = 1'b0; st[1] = 1'b1; t0[1] = cycle; armed[1] = 1'b1;
        cyc();
        st[1] = 1'b0;
        repeat (10) cyc();
        chk("stall_addr", 64'(addr[1]), FD);
        chk("held_head", 64'(d1[0]), 0);
        rdy[1] = 1'b1;
        wait_done(1, 40);
        repeat (2) cyc();

        // REPEAT=1, random ready
        rnd[1] = 1'b1; st[1] = 1'b1;
        cyc();
        st[1] = 1'b0;
        wait_done(1, 200);
        rnd[1] = 1'b0; rdy[1] = 1'b1;
        repeat (2) cyc();

        // REPEAT=2, asynchronous reset mid-pass, then a clean replay
        rdy[0] = 1'b1; st[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        repeat (5) cyc();
        #2 rst_v[0] = 1'b1;
        #1 chk_reset(0);
        exp_n[0] = 0; pend[0] = 1'b0; armed[0] = 1'b0;
        @(posedge clk); #1;
        cyc();
        rst_v[0] = 1'b0;
        repeat (3) begin
            cyc();
            chk("no_stale_beat", 64'(vld[0]), 0);
        end
        rnd[0] = 1'b1; st[0] = 1'b1; t0[0] = cycle; armed[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        wait_done(0, 300);
        rnd[0] = 1'b0; rdy[0] = 1'b1;

        // REPEAT=1, start held: back-to-back runs with one idle cycle between
        rdy[1] = 1'b1; st[1] = 1'b1;
        wait_done(1, 40);
        t0[1] = done_cyc[1]; armed[1] = 1'b1;
        wait_done(1, 40);
        st[1] = 1'b0;
        chk("idle_gap_seen", 64'(armed[1]), 0);
        repeat (3) cyc();

        // REPEAT=0: free-running from reset, start ignored, wraps forever
        rdy[2] = 1'b1; st[2] = 1'b1;
        rst_v[2] = 1'b0; t0[2] = cycle; armed[2] = 1'b1;
        repeat (30) cyc();
        chk("free_run_beats", 64'(exp_n[2]), 30 - (2 + LAT));
        st[2] = 1'b0;
        rnd[2] = 1'b1;
        repeat (40) cyc();
        chk("free_run_busy", 64'(busy[2]), 1);

        $display("test done: total=%0d bad=%0d", total_c, bad_c);
        $finish;
    end

endmodule
`default_nettype wire
